mips_ctrl_fsm: RTL and testbench



---
 rtl/mips_ctrl_pkg.sv | 42 ++++
 rtl/mips_ctrl_if.sv | 37 +++
 rtl/mips_alu_dec.sv | 32 +++
 rtl/mips_ctrl_fsm.sv | 148 ++++++++++++++
 tb/tb_mips_ctrl_fsm.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS control unit:
// opcode/funct encodings, ALU operation codes and the FSM state type.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_t;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Opcodes that proceed from DECODE into EXEC.
    function automatic logic op_known(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_ADDI) || (op == OP_BEQ) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_ctrl_if.sv
// Instruction/handshake inputs and datapath control outputs of the
// control unit; the FSM uses the slave view, the environment the master.
interface mips_ctrl_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pc_we;
    logic       ir_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       pc_src_br;
    logic       pc_src_j;
    logic [2:0] alu_op;
    logic       cu1;
    logic       cu3;
    logic       illegal;
    logic       halted;

    modport master (
        output opcode, funct, zero, mem_ready,
        input  pc_we, ir_we, mem_rd, mem_wr, alu_src, reg_dst, mem_to_reg,
               pc_src_br, pc_src_j, alu_op, cu1, cu3, illegal, halted
    );

    modport slave (
        input  opcode, funct, zero, mem_ready,
        output pc_we, ir_we, mem_rd, mem_wr, alu_src, reg_dst, mem_to_reg,
               pc_src_br, pc_src_j, alu_op, cu1, cu3, illegal, halted
    );

endinterface

// File: rtl/mips_alu_dec.sv
// Combinational (opcode, funct) -> ALU operation mapping. funct_ok_o is
// low only for an R-type with an unsupported funct field.
module mips_alu_dec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output alu_op_t    alu_op_o,
    output logic       funct_ok_o
);

    always_comb begin
        alu_op_o   = ALU_ADD;
        funct_ok_o = 1'b1;
        if (opcode_i == OP_RTYPE) begin
            case (funct_i)
                FN_ADD:  alu_op_o = ALU_ADD;
                FN_SUB:  alu_op_o = ALU_SUB;
                FN_AND:  alu_op_o = ALU_AND;
                FN_OR:   alu_op_o = ALU_OR;
                FN_SLT:  alu_op_o = ALU_SLT;
                default: begin
                    alu_op_o   = ALU_ADD;
                    funct_ok_o = 1'b0;
                end
            endcase
        end else if (opcode_i == OP_BEQ) begin
            alu_op_o = ALU_SUB;
        end
    end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle MIPS control FSM. Instruction fields are captured in DECODE
// so EXEC/MEM/WB controls depend only on state and registered decode.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_FETCH  | read instruction memory; on mem_ready load IR and PC+4
//   S_DECODE | capture opcode/funct, set cu1; dispatch, halt or flag illegal
//   S_EXEC   | ALU operation; branch/jump resolve here
//   S_MEM    | data memory read (LW) or write (SW), waits on mem_ready
//   S_WB     | register file write-back
//   S_HALT   | absorbing stop state, left only through rst
module mips_ctrl_fsm
    import mips_ctrl_pkg::*;
(
    input logic        clk,
    input logic        rst,
    mips_ctrl_if.slave bus
);

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] fn_q, fn_d;
    logic       cu1_q, cu1_d;
    logic       illegal_q, illegal_d;

    alu_op_t    dec_alu_op;
    logic       dec_funct_ok;
    logic       is_r, is_lw, kill_cu1;

    mips_alu_dec u_alu_dec (
        .opcode_i   (op_q),
        .funct_i    (fn_q),
        .alu_op_o   (dec_alu_op),
        .funct_ok_o (dec_funct_ok)
    );

    assign is_r  = (op_q == OP_RTYPE);
    assign is_lw = (op_q == OP_LW);
    // An R-type with an unsupported funct must not report a register write.
    assign kill_cu1 = (state_q == S_EXEC) && is_r && !dec_funct_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            fn_q      <= '0;
            cu1_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            fn_q      <= fn_d;
            cu1_q     <= cu1_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        fn_d           = fn_q;
        cu1_d          = cu1_q;
        illegal_d      = 1'b0;
        bus.pc_we      = 1'b0;
        bus.ir_we      = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.alu_src    = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.pc_src_br  = 1'b0;
        bus.pc_src_j   = 1'b0;
        bus.alu_op     = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                bus.mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_we = 1'b1;
                    bus.pc_we = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d  = bus.opcode;
                fn_d  = bus.funct;
                cu1_d = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_LW) ||
                        (bus.opcode == OP_ADDI);
                if (op_known(bus.opcode)) begin
                    state_d = S_EXEC;
                end else if (bus.opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                bus.alu_op = dec_alu_op;
                case (op_q)
                    OP_RTYPE: begin
                        state_d = S_WB;
                        if (!dec_funct_ok) cu1_d = 1'b0;
                    end
                    OP_LW, OP_SW: begin
                        bus.alu_src = 1'b1;
                        state_d     = S_MEM;
                    end
                    OP_ADDI: begin
                        bus.alu_src = 1'b1;
                        state_d     = S_WB;
                    end
                    OP_BEQ: begin
                        bus.pc_src_br = bus.zero;
                        bus.pc_we     = bus.zero;
                        state_d       = S_FETCH;
                    end
                    OP_J: begin
                        bus.pc_src_j = 1'b1;
                        bus.pc_we    = 1'b1;
                        state_d      = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                bus.mem_rd = is_lw;
                bus.mem_wr = !is_lw;
                if (bus.mem_ready) state_d = is_lw ? S_WB : S_FETCH;
            end
            S_WB: begin
                bus.reg_dst    = is_r;
                bus.mem_to_reg = is_lw;
                state_d        = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        if (state_d == S_FETCH) cu1_d = 1'b0;
    end

    assign bus.cu1     = cu1_q && !kill_cu1;
    assign bus.cu3     = (state_q == S_WB);
    assign bus.illegal = illegal_q;
    assign bus.halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Directed bench for mips_ctrl_fsm: each stimulus cycle queues the expected
// control vector; a negedge monitor pops and compares it.
module tb_mips_ctrl_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_ctrl_if bus();

    mips_ctrl_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [15:0] PCWE = 16'h8000, IRWE = 16'h4000, MRD = 16'h2000;
    localparam logic [15:0] MWR  = 16'h1000, ASRC = 16'h0800, RDST = 16'h0400;
    localparam logic [15:0] M2R  = 16'h0200, BR   = 16'h0100, JMP  = 16'h0080;
    localparam logic [15:0] A_SUB = 16'h0010, A_AND = 16'h0020, A_OR = 16'h0030;
    localparam logic [15:0] A_SLT = 16'h0040;
    localparam logic [15:0] CU1 = 16'h0008, CU3 = 16'h0004, ILL = 16'h0002, HLT = 16'h0001;
    localparam logic [15:0] FET = PCWE | IRWE | MRD;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, J = 6'b000010;
    localparam logic [5:0] HALT = 6'b111111, BADOP = 6'b010101;

    logic [15:0] exp_q[$];
    string       tag_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] obs;

    assign obs = {bus.pc_we, bus.ir_we, bus.mem_rd, bus.mem_wr, bus.alu_src,
                  bus.reg_dst, bus.mem_to_reg, bus.pc_src_br, bus.pc_src_j,
                  bus.alu_op, bus.cu1, bus.cu3, bus.illegal, bus.halted};

    always @(negedge clk) begin
        logic [15:0] e;
        string       t;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL %s: got %h want %h", t, obs, e);
            end
        end
    end

    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input logic chk,
                        input logic [15:0] e, input string t);
        @(posedge clk);
        #1;
        rst           = r;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.zero      = z;
        bus.mem_ready = rdy;
        if (chk) begin
            exp_q.push_back(e);
            tag_q.push_back(t);
        end
    endtask

    task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic rdy, input logic [15:0] e, input string t);
        step(1'b0, op, fn, z, rdy, 1'b1, e, t);
    endtask

    initial begin
        bus.opcode    = '0;
        bus.funct     = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        step(1'b1, R, 6'b100000, 1'b0, 1'b0, 1'b0, '0, "");

        cyc(R, 6'b100000, 0, 0, MRD, "reset_state");

        cyc(R, 6'b100000, 0, 1, FET, "add_fetch");
        cyc(R, 6'b100000, 0, 1, '0, "add_decode");
        cyc(R, 6'b100000, 0, 1, CU1, "add_exec");
        cyc(R, 6'b100000, 0, 1, CU1 | CU3 | RDST, "add_wb");

        cyc(R, 6'b100010, 0, 1, FET, "sub_fetch");
        cyc(R, 6'b100010, 0, 1, '0, "sub_decode");
        cyc(R, 6'b100010, 0, 1, CU1 | A_SUB, "sub_exec");
        cyc(R, 6'b100010, 0, 1, CU1 | CU3 | RDST, "sub_wb");

        cyc(R, 6'b101010, 0, 1, FET, "slt_fetch");
        cyc(R, 6'b101010, 0, 1, '0, "slt_decode");
        cyc(R, 6'b101010, 0, 1, CU1 | A_SLT, "slt_exec");
        cyc(R, 6'b101010, 0, 1, CU1 | CU3 | RDST, "slt_wb");

        cyc(R, 6'b100100, 0, 1, FET, "and_fetch");
        cyc(R, 6'b100100, 0, 1, '0, "and_decode");
        cyc(R, 6'b100100, 0, 1, CU1 | A_AND, "and_exec");
        cyc(R, 6'b100100, 0, 1, CU1 | CU3 | RDST, "and_wb");

        cyc(R, 6'b100101, 0, 1, FET, "or_fetch");
        cyc(R, 6'b100101, 0, 1, '0, "or_decode");
        cyc(R, 6'b100101, 0, 1, CU1 | A_OR, "or_exec");
        cyc(R, 6'b100101, 0, 1, CU1 | CU3 | RDST, "or_wb");

        cyc(R, 6'b000111, 0, 1, FET, "badfn_fetch");
        cyc(R, 6'b000111, 0, 1, '0, "badfn_decode");
        cyc(R, 6'b000111, 0, 1, '0, "badfn_exec");
        cyc(R, 6'b000111, 0, 1, CU3 | RDST, "badfn_wb");

        cyc(LW, 6'b000000, 0, 1, FET, "lw_fetch");
        cyc(LW, 6'b000000, 0, 1, '0, "lw_decode");
        cyc(LW, 6'b000000, 0, 1, ASRC | CU1, "lw_exec");
        cyc(LW, 6'b000000, 0, 0, MRD | CU1, "lw_mem_wait1");
        cyc(LW, 6'b000000, 0, 0, MRD | CU1, "lw_mem_wait2");
        cyc(LW, 6'b000000, 0, 1, MRD | CU1, "lw_mem_done");
        cyc(LW, 6'b000000, 0, 1, CU1 | CU3 | M2R, "lw_wb");

        cyc(ADDI, 6'b111000, 0, 1, FET, "addi_fetch");
        cyc(ADDI, 6'b111000, 0, 1, '0, "addi_decode");
        cyc(ADDI, 6'b111000, 0, 1, ASRC | CU1, "addi_exec");
        cyc(ADDI, 6'b111000, 0, 1, CU1 | CU3, "addi_wb");

        cyc(SW, 6'b000000, 0, 1, FET, "sw_fetch");
        cyc(SW, 6'b000000, 0, 1, '0, "sw_decode");
        cyc(SW, 6'b000000, 0, 1, ASRC, "sw_exec");
        cyc(SW, 6'b000000, 0, 1, MWR, "sw_mem");

        cyc(BEQ, 6'b000000, 1, 1, FET, "beq1_fetch");
        cyc(BEQ, 6'b000000, 1, 1, '0, "beq1_decode");
        cyc(BEQ, 6'b000000, 1, 1, A_SUB | BR | PCWE, "beq1_exec");
        cyc(BEQ, 6'b000000, 0, 1, FET, "beq0_fetch");
        cyc(BEQ, 6'b000000, 0, 1, '0, "beq0_decode");
        cyc(BEQ, 6'b000000, 0, 1, A_SUB, "beq0_exec");

        cyc(J, 6'b000000, 0, 1, FET, "j_fetch");
        cyc(J, 6'b000000, 0, 1, '0, "j_decode");
        cyc(J, 6'b000000, 0, 1, JMP | PCWE, "j_exec");

        cyc(BADOP, 6'b000000, 0, 1, FET, "ill_fetch");
        cyc(BADOP, 6'b000000, 0, 1, '0, "ill_decode");
        cyc(BADOP, 6'b000000, 0, 0, MRD | ILL, "ill_pulse");
        cyc(BADOP, 6'b000000, 0, 0, MRD, "ill_clear");

        cyc(SW, 6'b000000, 0, 1, FET, "swr_fetch");
        cyc(SW, 6'b000000, 0, 1, '0, "swr_decode");
        cyc(SW, 6'b000000, 0, 1, ASRC, "swr_exec");
        cyc(SW, 6'b000000, 0, 0, MWR, "swr_mem_wait");
        step(1'b1, SW, 6'b000000, 1'b0, 1'b0, 1'b1, MWR, "swr_mem_rst");
        cyc(SW, 6'b000000, 0, 0, MRD, "swr_after_rst");

        cyc(HALT, 6'b000000, 0, 1, FET, "halt_fetch");
        cyc(HALT, 6'b000000, 0, 1, '0, "halt_decode");
        for (int i = 0; i < 20; i++) begin
            logic [5:0] v;
            v = 6'(i * 7);
            cyc(v, ~v, v[0], v[1], HLT, "halt_hold");
        end
        step(1'b1, R, 6'b100000, 1'b1, 1'b1, 1'b1, HLT, "halt_rst");
        cyc(ADDI, 6'b000000, 0, 0, MRD, "halt_exit_fetch");
        cyc(ADDI, 6'b000000, 0, 1, FET, "resume_fetch");
        cyc(ADDI, 6'b000000, 0, 1, '0, "resume_decode");
        cyc(ADDI, 6'b000000, 0, 1, ASRC | CU1, "resume_exec");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
